read_mem: RTL and testbench

READ_MEM -- requirements
Module: read_mem

---
 rtl/read_mem.sv | 178 +++++++++++++++++
 tb/tb_read_mem.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_mem.sv
// read_mem: dumps the capture buffer to the host side, oldest sample first.
// It walks the buffer from the oldest location, issuing one synchronous read per word.
// Each word is offered on o_data/o_valid and is held until the downstream takes it.
// Optional feature: define READ_MEM_LAST_EN to add the o_last output, which marks
// the final word of a dump.
//
// Handshake (o_valid / o_ready):
//   o_valid rises only when o_data already holds the word being offered.
//   While o_valid=1 and o_ready=0, o_data and o_valid do not change.
//   A word is transferred on the rising clk edge where o_valid=1 and o_ready=1.
//   o_valid never falls without such a transfer, except on reset.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module read_mem #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic                  primed,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  o_ready,
`ifdef READ_MEM_LAST_EN
   output logic                  o_last,
`endif
   output logic                  busy,
   output logic                  done
);

   localparam int MEMORY_SIZE = 2 ** ADDR_WIDTH;

   // Word counts need one extra bit so a full buffer (MEMORY_SIZE words) fits.
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
   localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0] ZERO_COUNT = '0;

   // ADDR: read address presented; WAIT: read data in flight;
   // SEND: word offered downstream; DONE: one-cycle completion pulse.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t                state;
   state_t                next_state;

   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH-1:0] rptr_inc;
   logic [ADDR_WIDTH:0]   remaining;

   logic [ADDR_WIDTH-1:0] start_ptr;
   logic [ADDR_WIDTH:0]   start_count;
   logic                  accept;

   // Once the buffer has wrapped, the oldest sample sits at the write pointer
   // and every location is valid. Before that, data runs from 0 up to waddr-1.
   assign start_ptr   = primed ? waddr : '0;
   assign start_count = primed ? FULL_COUNT : {1'b0, waddr};

   // The pointer wraps modulo MEMORY_SIZE through natural overflow.
   assign rptr_inc    = rptr + 1'b1;
   assign accept      = (state == SEND) && o_valid && o_ready;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. start is only looked at in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (start_count == ZERO_COUNT) ? DONE : ADDR;
            end
         end
         ADDR: next_state = WAIT;
         WAIT: next_state = SEND;
         SEND: begin
            if (accept) begin
               next_state = (remaining == LAST_COUNT) ? DONE : ADDR;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status outputs are decoded directly from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Datapath: read pointer, word count, read address and output word register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr      <= '0;
         remaining <= '0;
         raddr     <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
`ifdef READ_MEM_LAST_EN
         o_last    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // waddr and primed matter only on the edge that accepts start.
               if (start) begin
                  rptr      <= start_ptr;
                  raddr     <= start_ptr;
                  remaining <= start_count;
               end
            end
            WAIT: begin
               // The read issued in ADDR has returned; capture it and offer it.
               o_data  <= rdata;
               o_valid <= 1'b1;
`ifdef READ_MEM_LAST_EN
               o_last  <= (remaining == LAST_COUNT);
`endif
            end
            SEND: begin
               if (accept) begin
                  o_valid   <= 1'b0;
`ifdef READ_MEM_LAST_EN
                  o_last    <= 1'b0;
`endif
                  rptr      <= rptr_inc;
                  raddr     <= rptr_inc;
                  remaining <= remaining - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Properties of the output stream that must always hold.
   a_hold_while_stalled : assert property (
      @(posedge clk) disable iff (!reset)
         (o_valid && !o_ready) |=> (o_valid && $stable(o_data))
   );

   a_valid_only_in_send : assert property (
      @(posedge clk) disable iff (!reset)
         o_valid |-> (state == SEND)
   );

   a_done_single_cycle : assert property (
      @(posedge clk) disable iff (!reset)
         done |=> !done
   );

endmodule

// File: tb/tb_read_mem.sv
// Directed bench for read_mem with ADDR_WIDTH=4, DATA_WIDTH=8.
// Buffer location i holds the value i+0x10.
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.

module tb_read_mem;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] waddr;
   logic       primed;
   logic [3:0] raddr;
   logic [7:0] rdata;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ready;
   logic       busy;
   logic       done;
`ifdef READ_MEM_LAST_EN
   logic       o_last;
`endif

   int tests;
   int fails;
   int words_seen;
   int cyc;
   int last_acc;
   bit gap_en;

   logic [7:0] exp_q[$];
   logic [7:0] mem[16];

   read_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .waddr  (waddr),
      .primed (primed),
      .raddr  (raddr),
      .rdata  (rdata),
      .o_data (o_data),
      .o_valid(o_valid),
      .o_ready(o_ready),
`ifdef READ_MEM_LAST_EN
      .o_last (o_last),
`endif
      .busy   (busy),
      .done   (done)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog in case a wait is never satisfied.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Capture buffer with a synchronous read port.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
   end

   always @(posedge clk) rdata <= mem[raddr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: each word seen with valid && ready is taken off the front of exp_q.
   always @(negedge clk) begin
      cyc++;
      if (reset && o_valid && o_ready) begin
         words_seen++;
         if (gap_en && last_acc >= 0) check("word_gap", cyc - last_acc, 3);
         last_acc = cyc;
         if (exp_q.size() > 0) begin
`ifdef READ_MEM_LAST_EN
            check("o_last", o_last, (exp_q.size() == 1) ? 1 : 0);
`endif
            check("word", o_data, exp_q.pop_front());
         end
      end
   end

   // Driver: a one-cycle start pulse. waddr and primed are then changed to other
   // values, so the dump shows whether the DUT kept the values from the start edge.
   task automatic pulse_start(input logic p, input logic [3:0] w);
      primed   = p;
      waddr    = w;
      start    = 1'b1;
      last_acc = -1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      primed = ~p;
      waddr  = 4'hB;
   endtask

   // Counts the edges, starting at the start edge, until o_valid is seen high.
   task automatic wait_valid(output int n);
      n = 0;
      @(negedge clk);
      while (!o_valid && n < 60) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Follows the dump until busy drops.
   task automatic wait_done(output int busy_cyc, output int done_cnt,
                            output int done_at, output int valid_cnt);
      int n;
      busy_cyc  = 0;
      done_cnt  = 0;
      done_at   = -1;
      valid_cnt = 0;
      n         = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         busy_cyc++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end
         if (o_valid) valid_cnt++;
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int bc;
      int dc;
      int da;
      int vc;
      int hold;
      int idle_act;

      tests      = 0;
      fails      = 0;
      words_seen = 0;
      cyc        = 0;
      last_acc   = -1;
      gap_en     = 1'b0;
      reset      = 1'b0;
      start      = 1'b0;
      waddr      = '0;
      primed     = 1'b0;
      o_ready    = 1'b1;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_o_valid", o_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_raddr", raddr, 0);
      check("rst_o_data", o_data, 0);
`ifdef READ_MEM_LAST_EN
      check("rst_o_last", o_last, 0);
`endif
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;

      // Not primed, waddr=5: words 0x10..0x14.
      gap_en = 1'b1;
      words_seen = 0;
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
      pulse_start(1'b0, 4'h5);
      wait_valid(n);
      // The start edge counts as edge 1; o_valid is seen high from edge 3.
      check("t1_first_valid_edges", n + 1, 3);
      wait_done(bc, dc, da, vc);
      check("t1_done_cnt", dc, 1);
      check("t1_busy_after", busy, 0);
      check("t1_words", words_seen, 5);
      check("t1_queue_left", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // Primed, waddr=0xE: 16 words, wrapping from 0x1F to 0x10.
      words_seen = 0;
      exp_q = '{8'h1E, 8'h1F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
      pulse_start(1'b1, 4'hE);
      wait_done(bc, dc, da, vc);
      check("t2_done_cnt", dc, 1);
      check("t2_busy_after", busy, 0);
      check("t2_words", words_seen, 16);
      check("t2_queue_left", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // Empty buffer: DONE follows IDLE directly and no word is offered.
      words_seen = 0;
      pulse_start(1'b0, 4'h0);
      wait_done(bc, dc, da, vc);
      check("t3_busy_cycles", bc, 1);
      check("t3_done_cnt", dc, 1);
      // done is high in the cycle right after the start edge, i.e. seen at the 2nd edge.
      check("t3_done_at", da, 0);
      check("t3_valid_cnt", vc, 0);
      check("t3_words", words_seen, 0);
      check("t3_busy_after", busy, 0);
      @(posedge clk);
      #1;

      // The second word is stalled by o_ready=0 for 10 cycles.
      gap_en = 1'b0;
      words_seen = 0;
      exp_q = '{8'h10, 8'h11, 8'h12};
      pulse_start(1'b0, 4'h3);
      wait_valid(n);
      @(posedge clk);
      #1 o_ready = 1'b0;
      wait_valid(n);
      hold = 0;
      for (int i = 0; i < 10; i++) begin
         if (o_valid && o_data == 8'h11) hold++;
         @(negedge clk);
      end
      check("t4_stall_hold", hold, 10);
      check("t4_words_during_stall", words_seen, 1);
      @(posedge clk);
      #1 o_ready = 1'b1;
      wait_done(bc, dc, da, vc);
      check("t4_done_cnt", dc, 1);
      check("t4_words", words_seen, 3);
      check("t4_queue_left", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // A start pulse in SEND must be ignored.
      words_seen = 0;
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
      o_ready = 1'b0;
      pulse_start(1'b0, 4'h4);
      wait_valid(n);
      @(posedge clk);
      #1;
      start  = 1'b1;
      primed = 1'b1;
      waddr  = 4'h9;
      @(posedge clk);
      #1;
      start   = 1'b0;
      o_ready = 1'b1;
      wait_done(bc, dc, da, vc);
      check("t5_done_cnt", dc, 1);
      check("t5_words", words_seen, 4);
      check("t5_queue_left", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // Reset is asserted between edges in the middle of a dump.
      words_seen = 0;
      exp_q = '{8'h16, 8'h17};
      pulse_start(1'b1, 4'h6);
      wait_valid(n);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_o_valid", o_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_raddr", raddr, 0);
      check("t6_rst_done", done, 0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      idle_act = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy || o_valid || done) idle_act++;
      end
      check("t6_idle_after_reset", idle_act, 0);
      @(posedge clk);
      #1;
      words_seen = 0;
      exp_q = '{8'h10, 8'h11};
      pulse_start(1'b0, 4'h2);
      wait_done(bc, dc, da, vc);
      check("t6_done_cnt", dc, 1);
      check("t6_words", words_seen, 2);
      check("t6_queue_left", exp_q.size(), 0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
